// File: rtl/vdata_seg_scanner.sv
// 8-digit multiplexed 7-segment scanner for the 32-bit debug value.
// Takes a frame-coherent snapshot, inserts an anti-ghost gap, and supports HOLD and leading-zero blanking.
module vdata_seg_scanner #(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Vdata,
    input  logic        HOLD,
    input  logic        LZB,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    localparam int            PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRES_MAX = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    OFF      = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0] pres_reg, pres_next;
    logic [2:0]    dig_reg, dig_next;
    logic [31:0]   snap_reg, snap_next;
    logic [7:0]    seg_reg, seg_next;
    logic [7:0]    an_reg, an_next;

    logic [7:0]    digit_live;
    logic          slot_blank;
    logic          lz_blank;
    logic          pres_wrap;
    logic          frame_start;
    logic [3:0]    nib;
    logic [7:0]    glyph_low;
    logic [7:0]    an_onehot;

    // digit_live[k]: some nibble at position k or above is non-zero
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_live
            assign digit_live[gi] = |snap_reg[31:4*gi];
        end
    endgenerate

    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign slot_blank = 1'b0;
        end else begin : g_gap
            assign slot_blank = (pres_reg < PW'(BLANK_CYC));
        end
    endgenerate

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign pres_wrap   = (pres_reg == PRES_MAX);
    assign frame_start = (dig_reg == 3'd0) && (pres_reg == '0);
    assign nib         = snap_reg[{dig_reg, 2'b00} +: 4];
    assign glyph_low   = hex_glyph(nib);
    assign an_onehot   = 8'b1 << dig_reg;
    assign lz_blank    = LZB && (dig_reg != 3'd0) && !digit_live[dig_reg];

    always_comb begin
        pres_next = pres_wrap ? '0 : pres_reg + 1'b1;
        dig_next  = pres_wrap ? dig_reg + 3'd1 : dig_reg;
        snap_next = (frame_start && !HOLD) ? Vdata : snap_reg;
        seg_next  = OFF;
        an_next   = OFF;
        if (!(slot_blank || lz_blank)) begin
            seg_next = (ACTIVE_LOW != 0) ? glyph_low : ~glyph_low;
            an_next  = (ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pres_reg <= '0;
            dig_reg  <= 3'd0;
            snap_reg <= 32'd0;
            seg_reg  <= OFF;
            an_reg   <= OFF;
        end else begin
            pres_reg <= pres_next;
            dig_reg  <= dig_next;
            snap_reg <= snap_next;
            seg_reg  <= seg_next;
            an_reg   <= an_next;
        end
    end

    assign SEG = seg_reg;
    assign AN  = an_reg;

endmodule

// File: tb/tb_vdata_seg_scanner.sv
// Bench for vdata_seg_scanner: directed phases plus random traffic against a
// timeline model (edge count since reset -> slot, digit, frame snapshot).
module tb_vdata_seg_scanner;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FRAME = 8 * SD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Vdata = 32'd0;
    logic        HOLD = 1'b0;
    logic        LZB = 1'b0;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    always #5 CLK = ~CLK;

    vdata_seg_scanner #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .ACTIVE_LOW(1)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Vdata(Vdata),
        .HOLD (HOLD),
        .LZB  (LZB),
        .SEG  (SEG),
        .AN   (AN)
    );

    int          tests = 0;
    int          fails = 0;
    int          n = 0;
    logic [31:0] m_snap = 32'd0;
    logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h n=%0d", tag, obs, exp, n);
        end
    endtask

    // One clock: predict the pins after this edge from the inputs present at it.
    task automatic step(input string tag);
        logic        r, h, l;
        logic [31:0] v;
        logic [7:0]  exp_an, exp_seg;
        logic [3:0]  nib;
        int          slot, d;
        @(posedge CLK);
        r = RST; h = HOLD; l = LZB; v = Vdata;
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
        if (r) begin
            n = 0;
            m_snap = 32'd0;
        end else begin
            slot = n % SD;
            d    = (n / SD) % 8;
            nib  = 4'(m_snap >> (4 * d));
            if (slot >= BC && !(l && d > 0 && (m_snap >> (4 * d)) == 32'd0)) begin
                exp_an  = ~(8'b1 << d);
                exp_seg = glyph[nib];
            end
            if (n % FRAME == 0 && !h) m_snap = v;
            n++;
        end
        #1;
        check32({tag, "_an"}, 32'(AN), 32'(exp_an));
        check32({tag, "_seg"}, 32'(SEG), 32'(exp_seg));
        check32({tag, "_snap"}, dut.snap_reg, m_snap);
        check32({tag, "_onehot"}, 32'($countones(~AN) <= 1), 32'd1);
    endtask

    initial begin
        int t0, t1, k;

        // 1: reset with all-ones input
        $display("[TB] phase reset");
        RST = 1'b1; Vdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) step("reset");
        RST = 1'b0;
        step("release");

        // 2: normal scan of 1234ABCD
        $display("[TB] phase scan 1234ABCD");
        Vdata = 32'h1234_ABCD;
        for (int i = 0; i < 31 + FRAME; i++) step("scan");

        // 3: digit-0 slot period
        $display("[TB] phase wrap");
        k = 0; while (AN !== 8'hFE && k < 40) begin step("wrap"); k++; end
        t0 = n;
        k = 0; while (AN === 8'hFE && k < 40) begin step("wrap"); k++; end
        k = 0; while (AN !== 8'hFE && k < 40) begin step("wrap"); k++; end
        t1 = n;
        check32("wrap_period", 32'(t1 - t0), 32'(FRAME));

        // 4: HOLD freezes, release takes effect at next frame start
        $display("[TB] phase hold");
        HOLD = 1'b1;
        step("hold");
        Vdata = 32'h0;
        for (int i = 0; i < 3 * FRAME; i++) step("hold");
        while (n % FRAME != 13) step("hold");
        HOLD = 1'b0;
        for (int i = 0; i < 40; i++) step("unhold");

        // 5: leading-zero blanking
        $display("[TB] phase lzb");
        LZB = 1'b1; Vdata = 32'h0000_00A0;
        for (int i = 0; i < 2 * FRAME; i++) step("lzb_a0");
        Vdata = 32'h0;
        for (int i = 0; i < 2 * FRAME; i++) step("lzb_zero");
        LZB = 1'b0;

        // 6: reset mid-frame at dig 5, pres 2
        $display("[TB] phase midreset");
        Vdata = 32'h8765_4321;
        while (n % FRAME != 5 * SD + 2) step("pre_rst");
        RST = 1'b1;
        step("mid_rst");
        RST = 1'b0;
        Vdata = 32'h0F0E_0D0C;
        for (int i = 0; i < 40; i++) step("post_rst");

        // 7: random traffic
        $display("[TB] phase random");
        for (int i = 0; i < 20 * FRAME; i++) begin
            Vdata = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) HOLD = ~HOLD;
            if ($urandom_range(0, 31) == 0) LZB = ~LZB;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
